mux2_8: RTL and testbench

- 8-bit 2:1 word multiplexer for datapath operand selection.
- Primary output y is purely combinational: y = s ? d1 : d0.
- A registered copy of the selected word (y_q) plus a valid flag is provided for pipelined consumers.
- Sits between register-file/immediate sources and downstream ALU or pipeline stages.

---
 rtl/mux2_8.sv | 53 +++++
 tb/tb_mux2_8.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mux2_8.sv
// rtl/mux2_8.sv - 2:1 word multiplexer with combinational output and registered copy
module mux2_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             s_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] y_d;
    logic             s_d;
    logic             valid_d;
    logic [WIDTH-1:0] y_reg_q;
    logic             s_reg_q;
    logic             valid_reg_q;

    assign y = s ? d1 : d0;

    always_comb begin
        y_d     = y_reg_q;
        s_d     = s_reg_q;
        valid_d = valid_reg_q;
        if (en) begin
            y_d     = y;
            s_d     = s;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg_q     <= '0;
            s_reg_q     <= 1'b0;
            valid_reg_q <= 1'b0;
        end else begin
            y_reg_q     <= y_d;
            s_reg_q     <= s_d;
            valid_reg_q <= valid_d;
        end
    end

    assign y_q     = y_reg_q;
    assign s_q     = s_reg_q;
    assign valid_q = valid_reg_q;

endmodule

// File: tb/tb_mux2_8.sv
// tb/tb_mux2_8.sv - directed self-checking bench for mux2_8
module tb_mux2_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       s;
    logic       en;
    logic [7:0] y;
    logic [7:0] y_q;
    logic       s_q;
    logic       valid_q;

    int n_cmp;
    int n_bad;

    mux2_8 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .s(s), .en(en),
        .y(y), .y_q(y_q), .s_q(s_q), .valid_q(valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ra [4];
    logic [7:0] rb [4];
    logic       prev_s;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        d0 = 8'h00; d1 = 8'h00; s = 1'b0; en = 1'b0;

        // Combinational select with known operands
        #2;
        d0 = 8'h24; d1 = 8'h81; s = 1'b0; #1;
        chk8("comb_s0", y, 8'h24);
        s = 1'b1; #1;
        chk8("comb_s1", y, 8'h81);

        // Fixed random-looking pairs, expected values hand-written
        ra[0] = 8'hA5; rb[0] = 8'h5A;
        ra[1] = 8'h13; rb[1] = 8'hE7;
        ra[2] = 8'hF0; rb[2] = 8'h0F;
        ra[3] = 8'h6C; rb[3] = 8'h39;
        for (int i = 0; i < 4; i++) begin
            d0 = ra[i]; d1 = rb[i];
            s = 1'b0; #1;
            chk8($sformatf("rand%0d_s0", i), y, ra[i]);
            s = 1'b1; #1;
            chk8($sformatf("rand%0d_s1", i), y, rb[i]);
        end

        // Extremes and swapped extremes
        d0 = 8'h00; d1 = 8'hFF; s = 1'b0; #1;
        chk8("ext_s0", y, 8'h00);
        s = 1'b1; #1;
        chk8("ext_s1", y, 8'hFF);
        d0 = 8'hFF; d1 = 8'h00; s = 1'b0; #1;
        chk8("swap_s0", y, 8'hFF);
        s = 1'b1; #1;
        chk8("swap_s1", y, 8'h00);

        // Reset held while clock toggles and en=1
        d0 = 8'h5A; d1 = 8'h11; s = 1'b0; en = 1'b1;
        step; step;
        chk8("rst_y", y, 8'h5A);
        chk8("rst_yq", y_q, 8'h00);
        chk1("rst_sq", s_q, 1'b0);
        chk1("rst_valid", valid_q, 1'b0);

        // Release between edges; first edge captures
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rel_valid_before_edge", valid_q, 1'b0);
        step;
        chk8("first_yq", y_q, 8'h5A);
        chk1("first_sq", s_q, 1'b0);
        chk1("first_valid", valid_q, 1'b1);

        // Enable hold
        @(negedge clk);
        d1 = 8'h3C; s = 1'b1; en = 1'b1;
        step;
        chk8("cap_yq", y_q, 8'h3C);
        chk1("cap_sq", s_q, 1'b1);
        @(negedge clk);
        en = 1'b0; d1 = 8'hC3; s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk8($sformatf("hold%0d_yq", i), y_q, 8'h3C);
            chk8($sformatf("hold%0d_y", i), y, 8'hC3);
            chk1($sformatf("hold%0d_valid", i), valid_q, 1'b1);
        end
        // s change while disabled must not reach s_q
        @(negedge clk);
        s = 1'b0;
        step;
        chk1("hold_sq", s_q, 1'b1);
        chk8("hold_yq2", y_q, 8'h3C);

        // Mid-operation reset between edges, en active so a capture is pending
        @(negedge clk);
        en = 1'b1; s = 1'b1; d1 = 8'h77;
        #1;
        rst_n = 1'b0;
        #1;
        chk8("mid_rst_yq", y_q, 8'h00);
        chk1("mid_rst_valid", valid_q, 1'b0);
        chk1("mid_rst_sq", s_q, 1'b0);
        step;
        chk8("mid_rst_discard", y_q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal inputs, s toggling every cycle
        d0 = 8'h99; d1 = 8'h99; s = 1'b0; en = 1'b1;
        step;
        prev_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s = ~s;
            #1;
            chk8($sformatf("eq%0d_y", i), y, 8'h99);
            step;
            chk8($sformatf("eq%0d_yq", i), y_q, 8'h99);
            chk1($sformatf("eq%0d_sq", i), s_q, ~prev_s);
            prev_s = ~prev_s;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
